// File: rtl/count_arbiter_pkg.sv
// rtl/count_arbiter_pkg.sv - shared constants and FSM encoding for count_arbiter
package count_arbiter_pkg;

  localparam int CNT_W = 4;
  localparam int NREQ  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    REST = 2'd2
  } state_t;

endpackage

// File: rtl/count_arbiter_count_core.sv
// rtl/count_arbiter_count_core.sv - shared run counter with synchronous clear and increment enable
module count_core
  import count_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] value
);

  // Clear wins over increment so the arbiter can park the counter at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/count_arbiter.sv
// rtl/count_arbiter.sv - two-requester arbiter for one shared counter; ROUND_ROBIN_EN selects round-robin ties
module count_arbiter
  import count_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [CNT_W-1:0] len0,
  input  logic [CNT_W-1:0] len1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [CNT_W-1:0] cnt,
  output logic             done0,
  output logic             done1,
  output logic             busy
);

  state_t           state_q;
  state_t           state_d;
  logic             owner_q;
  logic [CNT_W-1:0] len_q;
  logic [NREQ-1:0]  req_vec;
  logic             any_req;
  logic             owner_req;
  logic             at_end;
  logic             win;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             in_run;

  assign req_vec   = {req1, req0};
  assign any_req   = |req_vec;
  assign owner_req = req_vec[owner_q];
  assign at_end    = (cnt == len_q);
  assign in_run    = (state_q == RUN);

`ifdef ROUND_ROBIN_EN
  logic last_q;

  // Remember who won the last arbitration; reset value lets requester 0 take the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (state_q == IDLE && any_req) begin
      last_q <= win;
    end
  end

  // Winner select: a lone request wins, a tie goes to whoever did not win last.
  always_comb begin
    win = 1'b0;
    if (req1 && !req0) begin
      win = 1'b1;
    end else if (req0 && req1) begin
      win = ~last_q;
    end
  end
`else
  // Winner select: a lone request wins, a tie always goes to requester 0.
  always_comb begin
    win = 1'b0;
    if (req1 && !req0) begin
      win = 1'b1;
    end
  end
`endif

  // State register plus the owner and terminal count captured at grant time.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && any_req) begin
        owner_q <= win;
        len_q   <= win ? len1 : len0;
      end
    end
  end

  // Next state and counter control; the counter is held clear whenever no run is active.
  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b1;
    cnt_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!owner_req || at_end) begin
          state_d = REST;
        end else begin
          cnt_clr = 1'b0;
          cnt_inc = 1'b1;
        end
      end
      REST: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  count_core u_count_core (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .value (cnt)
  );

  // An abandoned run (owner request low) never reports done, even on its last count.
  assign gnt0  = in_run && !owner_q;
  assign gnt1  = in_run &&  owner_q;
  assign done0 = gnt0 && req0 && at_end;
  assign done1 = gnt1 && req1 && at_end;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_count_arbiter.sv
// tb/tb_count_arbiter.sv - self-checking bench for count_arbiter with a reference model
module tb_count_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1;
  logic [3:0] len0, len1;
  logic       gnt0, gnt1, done0, done1, busy;
  logic [3:0] cnt;

  int tests = 0;
  int fails = 0;

  // reference model: phase 0 idle, 1 counting, 2 rest
  int m_phase, m_owner, m_cnt, m_len, m_last;

  logic       o_g0, o_g1, o_d0, o_d1, o_busy;
  logic [3:0] o_cnt;

  always #5 clk = ~clk;

  count_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .len0(len0), .len1(len1),
    .gnt0(gnt0), .gnt1(gnt1), .cnt(cnt), .done0(done0), .done1(done1), .busy(busy)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic r0, input logic r1);
    if (r0 && r1) begin
`ifdef ROUND_ROBIN_EN
      return (m_last == 0) ? 1 : 0;
`else
      return 0;
`endif
    end
    return r1 ? 1 : 0;
  endfunction

  task automatic step(input logic r0, input logic r1, input logic [3:0] l0,
                      input logic [3:0] l1, input logic rn);
    logic e_g0, e_g1, e_d0, e_d1, e_busy;
    logic [3:0] e_cnt;
    int w;
    @(negedge clk);
    req0 = r0; req1 = r1; len0 = l0; len1 = l1; rst_n = rn;
    #1;
    o_g0 = gnt0; o_g1 = gnt1; o_d0 = done0; o_d1 = done1; o_busy = busy; o_cnt = cnt;
    e_g0 = 0; e_g1 = 0; e_d0 = 0; e_d1 = 0; e_cnt = 0;
    e_busy = (m_phase != 0);
    if (m_phase == 1) begin
      e_cnt = 4'(m_cnt);
      if (m_owner == 0) begin
        e_g0 = 1;
        e_d0 = r0 && (m_cnt == m_len);
      end else begin
        e_g1 = 1;
        e_d1 = r1 && (m_cnt == m_len);
      end
    end
    check("cycle{g0,g1,cnt,d0,d1,busy}", {7'd0, o_g0, o_g1, o_cnt, o_d0, o_d1, o_busy},
          {7'd0, e_g0, e_g1, e_cnt, e_d0, e_d1, e_busy});
    @(posedge clk);
    if (!rn) begin
      m_phase = 0; m_cnt = 0; m_len = 0; m_last = 1; m_owner = 0;
    end else if (m_phase == 0) begin
      if (r0 || r1) begin
        w = pick(r0, r1);
        m_phase = 1; m_owner = w; m_cnt = 0; m_last = w;
        m_len = (w == 1) ? int'(l1) : int'(l0);
      end
    end else if (m_phase == 1) begin
      if (!((m_owner == 1) ? r1 : r0) || m_cnt == m_len) m_phase = 2;
      else m_cnt++;
    end else begin
      m_phase = 0;
    end
  endtask

  initial begin
    int   cq[$];
    int   grants[$];
    int   exp_g[4];
    logic prev;
    logic seen_done;
    logic r0, r1;

    m_phase = 0; m_owner = 0; m_cnt = 0; m_len = 0; m_last = 1;
    rst_n = 1'b0; req0 = 0; req1 = 0; len0 = 0; len1 = 0;
    repeat (2) @(posedge clk);

    // reset state
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    check("reset_outputs", {10'd0, o_g0, o_g1, o_d0, o_d1, o_busy, 1'b0}, 16'd0);
    check("reset_cnt", {12'd0, o_cnt}, 16'd0);

    // single request, len 3
    step(1, 0, 3, 0, 1);
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 3, 0, 1);
      if (o_g0) cq.push_back(int'(o_cnt));
      if (o_d0) break;
    end
    check("single_run_len", 16'(cq.size()), 16'd4);
    for (int i = 0; i < 4 && i < cq.size(); i++) check("single_cnt_seq", 16'(cq[i]), 16'(i));
    check("single_done_cnt", {12'd0, o_cnt}, 16'd3);
    step(0, 0, 3, 0, 1);
    check("single_rest_busy_gnt", {14'd0, o_busy, o_g0}, 16'b10);
    step(0, 0, 0, 0, 1);

    // len 0 on requester 1
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    check("len0_gnt_done", {11'd0, o_g1, o_d1, o_cnt}, {11'd0, 1'b1, 1'b1, 4'd0});
    step(0, 0, 0, 0, 1);
    check("len0_rest", {14'd0, o_busy, o_g1}, 16'b10);
    step(0, 0, 0, 0, 1);

    // tie with both requests held
    step(0, 0, 0, 0, 0);
    prev = 0;
    for (int i = 0; i < 15; i++) begin
      step(1, 1, 1, 1, 1);
      if ((o_g0 || o_g1) && !prev) grants.push_back(o_g1 ? 1 : 0);
      prev = o_g0 || o_g1;
    end
`ifdef ROUND_ROBIN_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    check("tie_grant_count", 16'(grants.size()), 16'd4);
    for (int i = 0; i < 4 && i < grants.size(); i++) check("tie_grant_order", 16'(grants[i]), 16'(exp_g[i]));
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);

    // abort when cnt=2
    seen_done = 0;
    step(1, 0, 7, 0, 1);
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 7, 0, 1);
      seen_done |= o_d0;
      if (o_g0 && o_cnt == 4'd1) break;
    end
    step(0, 0, 7, 0, 1);
    seen_done |= o_d0;
    check("abort_last_run_cycle", {11'd0, o_g0, o_d0, o_cnt}, {11'd0, 1'b1, 1'b0, 4'd2});
    step(0, 0, 7, 0, 1);
    seen_done |= o_d0;
    check("abort_rest", {14'd0, o_busy, o_g0}, 16'b10);
    step(0, 0, 7, 0, 1);
    check("abort_idle", {15'd0, o_busy}, 16'd0);
    check("abort_no_done", {15'd0, seen_done}, 16'd0);

    // reset mid-run at cnt=5, then tie goes to requester 0
    step(1, 0, 9, 0, 1);
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 9, 0, 1);
      if (o_g0 && o_cnt == 4'd4) break;
    end
    step(1, 0, 9, 0, 0);
    check("rst_mid_cnt", {12'd0, o_cnt}, 16'd5);
    step(1, 1, 1, 1, 1);
    check("rst_mid_all_zero", {7'd0, o_g0, o_g1, o_cnt, o_d0, o_d1, o_busy}, 16'd0);
    step(1, 1, 1, 1, 1);
    check("rst_tie_gnt0", {14'd0, o_g0, o_g1}, 16'b10);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);

    // len change mid-run is ignored
    step(1, 0, 3, 0, 1);
    seen_done = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 9, 0, 1);
      if (o_d0) begin
        seen_done = 1;
        break;
      end
    end
    check("lenchg_done_seen", {15'd0, seen_done}, 16'd1);
    check("lenchg_done_cnt", {12'd0, o_cnt}, 16'd3);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);

    // randomized traffic against the model
    r0 = 0; r1 = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) r0 = ~r0;
      if ($urandom_range(0, 7) == 0) r1 = ~r1;
      step(r0, r1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 60) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
